fmeasure_sequencer: RTL and testbench

Measurement controller directly upstream of the ring-oscillator frequency counter. On a start request it clears the counter and opens its gate for a programmable power-of-two number of clk cycles. It then waits for the counter's gate synchronisers to drain, captures the counter's cycle count, and reports it with a done pulse. Runs entirely in the system clk domain; the counter runs on the oscillator clock and consumes gate and counter_reset.

---
 rtl/fmeasure_sequencer.sv | 178 +++++++++++++++++
 tb/tb_fmeasure_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fmeasure_sequencer.sv
// fmeasure_sequencer
//   Measurement controller for the ring-oscillator frequency counter.
//   On start it clears the counter, opens the gate for 2^window_sel clk cycles,
//   waits for the counter's gate synchronisers to drain, then captures the count.
//
// Ports
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   start          in   request a measurement (sampled only in IDLE)
//   abort          in   cancel the measurement in progress
//   window_sel     in   gate length exponent, latched at start
//   cycle_count    in   count from the frequency counter
//   counter_reset  out  clear pulse to the counter
//   gate           out  counting window to the counter
//   result         out  last captured count
//   result_valid   out  result holds a completed measurement
//   busy           out  measurement in progress
//   done           out  one-cycle pulse, result just updated
module fmeasure_sequencer #(
  parameter int LENGTH        = 20,
  parameter int GATE_BITS     = 16,
  parameter int RESET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        window_sel,
  input  logic [LENGTH-1:0] cycle_count,
  output logic              counter_reset,
  output logic              gate,
  output logic [LENGTH-1:0] result,
  output logic              result_valid,
  output logic              busy,
  output logic              done
);

  localparam int CLR_W = $clog2(RESET_CYCLES) + 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;

  localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(RESET_CYCLES - 1);
  // SETTLE covers S-1 cycles; the final settle cycle is spent in CAPTURE.
  localparam logic [SET_W-1:0] SET_LOAD =
    SET_W'((SETTLE_CYCLES >= 2) ? (SETTLE_CYCLES - 2) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_OPEN,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  state_t                r_state,  w_state;
  logic [CLR_W-1:0]      r_clr_cnt, w_clr_cnt;
  logic [GATE_BITS-1:0]  r_win_cnt, w_win_cnt;
  logic [SET_W-1:0]      r_set_cnt, w_set_cnt;
  logic [3:0]            r_win_exp, w_win_exp;
  logic                  r_counter_reset, w_counter_reset;
  logic                  r_gate, w_gate;
  logic [LENGTH-1:0]     r_result, w_result;
  logic                  r_result_valid, w_result_valid;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_clr_cnt       <= '0;
      r_win_cnt       <= '0;
      r_set_cnt       <= '0;
      r_win_exp       <= '0;
      r_counter_reset <= 1'b0;
      r_gate          <= 1'b0;
      r_result        <= '0;
      r_result_valid  <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state         <= w_state;
      r_clr_cnt       <= w_clr_cnt;
      r_win_cnt       <= w_win_cnt;
      r_set_cnt       <= w_set_cnt;
      r_win_exp       <= w_win_exp;
      r_counter_reset <= w_counter_reset;
      r_gate          <= w_gate;
      r_result        <= w_result;
      r_result_valid  <= w_result_valid;
      r_busy          <= w_busy;
      r_done          <= w_done;
    end
  end

  always_comb begin
    w_state         = r_state;
    w_clr_cnt       = r_clr_cnt;
    w_win_cnt       = r_win_cnt;
    w_set_cnt       = r_set_cnt;
    w_win_exp       = r_win_exp;
    w_counter_reset = r_counter_reset;
    w_gate          = r_gate;
    w_result        = r_result;
    w_result_valid  = r_result_valid;
    w_busy          = r_busy;
    w_done          = 1'b0;

    if (abort && (r_state != S_IDLE)) begin
      w_state         = S_IDLE;
      w_gate          = 1'b0;
      w_counter_reset = 1'b0;
      w_busy          = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // abort outranks start even though it has nothing to cancel here
          if (start && !abort) begin
            w_state         = S_CLEAR;
            w_counter_reset = 1'b1;
            w_busy          = 1'b1;
            w_result_valid  = 1'b0;
            w_clr_cnt       = CLR_LOAD;
            if (int'(window_sel) > GATE_BITS - 1)
              w_win_exp = 4'(GATE_BITS - 1);
            else
              w_win_exp = window_sel;
          end
        end
        S_CLEAR: begin
          if (r_clr_cnt == '0) begin
            w_state         = S_OPEN;
            w_counter_reset = 1'b0;
            w_gate          = 1'b1;
            w_win_cnt       = (GATE_BITS'(1) << r_win_exp) - GATE_BITS'(1);
          end else begin
            w_clr_cnt = r_clr_cnt - 1'b1;
          end
        end
        S_OPEN: begin
          if (r_win_cnt == '0) begin
            w_gate    = 1'b0;
            w_set_cnt = SET_LOAD;
            w_state   = (SETTLE_CYCLES == 1) ? S_CAPTURE : S_SETTLE;
          end else begin
            w_win_cnt = r_win_cnt - 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_set_cnt == '0)
            w_state = S_CAPTURE;
          else
            w_set_cnt = r_set_cnt - 1'b1;
        end
        S_CAPTURE: begin
          w_state        = S_IDLE;
          w_result       = cycle_count;
          w_result_valid = 1'b1;
          w_done         = 1'b1;
          w_busy         = 1'b0;
        end
        default: begin
          w_state         = S_IDLE;
          w_gate          = 1'b0;
          w_counter_reset = 1'b0;
          w_busy          = 1'b0;
        end
      endcase
    end
  end

  assign counter_reset = r_counter_reset;
  assign gate          = r_gate;
  assign result        = r_result;
  assign result_valid  = r_result_valid;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_fmeasure_sequencer.sv
// tb_fmeasure_sequencer
//   Directed and randomised measurements of fmeasure_sequencer with default
//   parameters. Expected waveforms are derived from the start-relative timeline:
//   counter_reset for R cycles, gate for 2^window_sel cycles, settle for S cycles,
//   then a one-cycle done with the captured count.
module tb_fmeasure_sequencer;

  localparam int LENGTH    = 20;
  localparam int GATE_BITS = 16;
  localparam int R         = 4;
  localparam int S         = 8;

  logic              clk;
  logic              reset;
  logic              start;
  logic              abort;
  logic [3:0]        window_sel;
  logic [LENGTH-1:0] cycle_count;
  logic              counter_reset;
  logic              gate;
  logic [LENGTH-1:0] result;
  logic              result_valid;
  logic              busy;
  logic              done;

  int checks;
  int failures;
  logic [LENGTH-1:0] prev_result;

  fmeasure_sequencer #(
    .LENGTH(LENGTH),
    .GATE_BITS(GATE_BITS),
    .RESET_CYCLES(R),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .window_sel(window_sel),
    .cycle_count(cycle_count),
    .counter_reset(counter_reset),
    .gate(gate),
    .result(result),
    .result_valid(result_valid),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input bit e_cr, input bit e_gate, input bit e_busy,
                         input bit e_done, input bit e_rv, input logic [LENGTH-1:0] e_res);
    chk({tag, ".counter_reset"}, 32'(counter_reset), 32'(e_cr));
    chk({tag, ".gate"},          32'(gate),          32'(e_gate));
    chk({tag, ".busy"},          32'(busy),          32'(e_busy));
    chk({tag, ".done"},          32'(done),          32'(e_done));
    chk({tag, ".result_valid"},  32'(result_valid),  32'(e_rv));
    chk({tag, ".result"},        32'(result),        32'(e_res));
  endtask

  // One measurement. k counts edges since the start-accepting edge E0.
  // kill_kind: 0 none, 1 abort raised at k==kill_k, 2 reset raised at k==kill_k.
  // ws_after < 0 randomises window_sel after E0.
  task automatic measure(input string tag, input int ws, input int ws_after,
                         input logic [LENGTH-1:0] cc_final, input int kill_k,
                         input int kill_kind, input bit hold);
    int wexp;
    int w;
    int n;
    bit killed;
    wexp = (ws > GATE_BITS - 1) ? GATE_BITS - 1 : ws;
    w = 1 << wexp;
    n = R + w + S;
    killed = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    window_sel = 4'(ws);
    for (int k = 0; k <= n; k++) begin
      tick();
      chk_all(tag, (k < R), (k >= R) && (k < R + w), (k < n), (k == n), (k == n),
              (k == n) ? cc_final : prev_result);
      if (k == n) break;
      window_sel  = (ws_after >= 0) ? 4'(ws_after) : 4'($urandom_range(0, 15));
      start       = hold ? 1'b1 : ($urandom_range(0, 3) == 0);
      cycle_count = (k >= R + w) ? cc_final : LENGTH'($urandom);
      if (kill_kind != 0 && k == kill_k) begin
        start = 1'b0;
        if (kill_kind == 1) abort = 1'b1;
        else reset = 1'b1;
        killed = 1'b1;
        break;
      end
    end
    if (killed) begin
      tick();
      abort = 1'b0;
      reset = 1'b0;
      if (kill_kind == 2) prev_result = '0;
      for (int j = 0; j < 3; j++) begin
        chk_all({tag, ".killed"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, prev_result);
        tick();
      end
    end else begin
      prev_result = cc_final;
      if (!hold) start = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    prev_result = '0;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    window_sel = '0;
    cycle_count = '0;
    tick();
    tick();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    reset = 1'b0;
    tick();
    chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // window 8, count 1000: done at E20
    measure("ws3", 3, -1, 20'd1000, 0, 0, 1'b0);
    tick();

    // abort while idle does nothing; abort together with start blocks the start
    abort = 1'b1;
    tick();
    chk_all("idle_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'd1000);
    start = 1'b1;
    tick();
    chk_all("abort_over_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'd1000);
    abort = 1'b0;
    start = 1'b0;
    tick();

    // abort two cycles into OPEN keeps 1000, clears result_valid
    measure("abort_open", 3, -1, 20'd55, R + 1, 1, 1'b0);
    measure("after_abort", 3, -1, 20'd777, 0, 0, 1'b0);
    measure("ws0", 0, -1, LENGTH'($urandom), 0, 0, 1'b0);

    // start held: each measurement follows immediately after the previous done
    measure("held0", 1, 2, LENGTH'($urandom), 0, 0, 1'b1);
    measure("held1", 2, 0, LENGTH'($urandom), 0, 0, 1'b1);
    measure("held2", 0, 5, LENGTH'($urandom), 0, 0, 1'b0);
    tick();

    // window_sel changed after E0 has no effect; full-scale count
    measure("ws_change", 3, 7, 20'hFFFFF, 0, 0, 1'b0);

    // synchronous reset during SETTLE
    measure("reset_settle", 2, -1, 20'd321, R + 4 + 2, 2, 1'b0);

    for (int i = 0; i < 8; i++) begin
      int ws;
      int kind;
      int kk;
      ws = $urandom_range(0, 6);
      kind = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0;
      kk = $urandom_range(0, R + (1 << ws) + S - 1);
      measure("random", ws, -1, LENGTH'($urandom), kk, kind, 1'b0);
      if ($urandom_range(0, 1) == 1) tick();
    end

    measure("ws15", 15, -1, LENGTH'($urandom), 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
